// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-drive bundle for alu_op_sequencer.
// slave is the sequencer side; master is the requester/ALU/consumer side.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [2:0]        req_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_overflow;
  logic              alu_error;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_flags;

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    input  alu_out, alu_zero, alu_carry, alu_overflow, alu_error,
    input  rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_data, rsp_flags
  );

  modport master (
    output req_valid, req_a, req_b, req_sel,
    output alu_out, alu_zero, alu_carry, alu_overflow, alu_error,
    output rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_data, rsp_flags
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the 2-bit ALU: request handshake, settle wait, response FIFO.
// Optional STICKY_FLAGS_EN adds accumulated {error,overflow,carry} flags.
module alu_op_sequencer #(
  parameter int unsigned DATA_W     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [7:0]          op_count
`ifdef STICKY_FLAGS_EN
  ,
  input  logic                sticky_clr,
  output logic [2:0]          sticky_flags
`endif
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned EntW = DATA_W + 4;
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   settle_q, settle_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic [EntW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [7:0]        op_count_q, op_count_d;
  logic              req_ready, push, pop, rsp_valid;
  logic [EntW-1:0]   push_entry, head;

  assign push_entry = {bus.alu_error, bus.alu_overflow, bus.alu_carry, bus.alu_zero,
                       bus.alu_out};
  assign rsp_valid  = (count_q != '0);
  assign pop        = rsp_valid && bus.rsp_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    req_ready = 1'b0;
    push      = 1'b0;
    case (state_q)
      StIdle: begin
        // At most one op in flight, so a free slot at accept guarantees room at push.
        req_ready = !rst && (count_q < DepthC);
        if (bus.req_valid && req_ready) begin
          alu_a_d   = bus.req_a;
          alu_b_d   = bus.req_b;
          alu_sel_d = bus.req_sel;
          settle_d  = CntW'(SETTLE_CYC - 1);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (settle_q == '0) begin
          push    = 1'b1;
          state_d = StIdle;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    op_count_d = push ? op_count_q + 8'd1 : op_count_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign bus.req_ready = req_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_valid ? head[DATA_W-1:0] : '0;
  assign bus.rsp_flags = rsp_valid ? head[EntW-1:DATA_W] : '0;
  assign op_count      = op_count_q;

`ifdef STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;

  // Clear first, then OR: a coincident push leaves only that push's flags.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = 3'b000;
    if (push)       sticky_d = sticky_d | push_entry[EntW-1:DATA_W+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 3'b000;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural 2-bit ALU attached.
// Define STICKY_FLAGS_EN to also exercise the sticky flag ports.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] op_count;
  int         checks = 0;
  int         passed = 0;
  logic [5:0] exp_q[$];

  alu_op_sequencer_if #(.DATA_W(2)) bus ();

`ifdef STICKY_FLAGS_EN
  logic       sticky_clr = 1'b0;
  logic [2:0] sticky_flags;
`endif

  alu_op_sequencer #(.DATA_W(2), .FIFO_DEPTH(4), .SETTLE_CYC(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .op_count     (op_count)
`ifdef STICKY_FLAGS_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {error, overflow, carry, zero, out[1:0]}; SUB carry is borrow.
  function automatic logic [5:0] alu_ref(input logic [1:0] a, input logic [1:0] b,
                                         input logic [2:0] sel);
    logic [2:0] w;
    logic [1:0] o;
    logic       c, v, e;
    w = 3'd0; o = 2'd0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (sel)
      3'b000: begin
        w = {1'b0, a} + {1'b0, b}; o = w[1:0]; c = w[2];
        v = (a[1] == b[1]) && (o[1] != a[1]);
      end
      3'b001: begin
        w = {1'b0, a} - {1'b0, b}; o = w[1:0]; c = w[2];
        v = (a[1] != b[1]) && (o[1] != a[1]);
      end
      3'b010:  o = a & b;
      3'b011:  o = a | b;
      default: e = 1'b1;
    endcase
    return {e, v, c, (o == 2'b00), o};
  endfunction

  assign {bus.alu_error, bus.alu_overflow, bus.alu_carry, bus.alu_zero, bus.alu_out} =
      alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [1:0] a, input logic [1:0] b, input logic [2:0] sel);
    bit ok = 0;
    bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_sel = sel;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.req_ready) ok = 1;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    checks++;
    if (!ok) $display("FAIL issue_timeout: accepted=%0d required=1", ok);
    else begin passed++; exp_q.push_back(alu_ref(a, b, sel)); end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_sel = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %0b want 0", bus.req_ready);
    else passed++;
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_flags} !== 7'd0)
      $display("FAIL reset_rsp: got %0h want 0", {bus.rsp_valid, bus.rsp_data, bus.rsp_flags});
    else passed++;
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel, op_count} !== 15'd0)
      $display("FAIL reset_alu_cnt: got %0h want 0", {bus.alu_a, bus.alu_b, bus.alu_sel, op_count});
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL post_reset_ready: got %0b want 1", bus.req_ready);
    else passed++;
  endtask

  task automatic test_directed();
    logic [12:0] vec [6] = '{
      {2'b01, 2'b01, 3'b000, 2'b10, 4'b0100},
      {2'b11, 2'b01, 3'b000, 2'b00, 4'b0011},
      {2'b11, 2'b01, 3'b001, 2'b10, 4'b0000},
      {2'b11, 2'b01, 3'b010, 2'b01, 4'b0000},
      {2'b10, 2'b01, 3'b011, 2'b11, 4'b0000},
      {2'b01, 2'b10, 3'b100, 2'b00, 4'b1001}};
    logic [1:0] a, b, ed;
    logic [2:0] sel;
    logic [3:0] ef;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      {a, b, sel, ed, ef} = vec[i];
      issue(a, b, sel);
      if (i == 0) begin
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b00)
          $display("FAIL wait_state: got ready,valid=%b want 00", {bus.req_ready, bus.rsp_valid});
        else passed++;
      end
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_flags} !== {1'b1, ed, ef})
        $display("FAIL directed_%0d: got %b want %b", i,
                 {bus.rsp_valid, bus.rsp_data, bus.rsp_flags}, {1'b1, ed, ef});
      else passed++;
      checks++;
      if (op_count !== 8'(i + 1)) $display("FAIL op_count_%0d: got %0d want %0d", i, op_count, i + 1);
      else passed++;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b01)
      $display("FAIL full_ready: got ready,valid=%b want 01", {bus.req_ready, bus.rsp_valid});
    else passed++;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.rsp_valid, bus.rsp_flags, bus.rsp_data} !== {1'b1, e})
        $display("FAIL drain_%0d: got %b want %b", i,
                 {bus.rsp_valid, bus.rsp_flags, bus.rsp_data}, {1'b1, e});
      else passed++;
      @(negedge clk);
      if (i == 0) begin
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL one_pop_ready: got %0b want 1", bus.req_ready);
        else passed++;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
      end
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL drained_empty: got %0b want 0", bus.rsp_valid);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] base = op_count;
    logic [5:0] e;
    int         n_acc = 0;
    for (int cyc = 0; cyc < 3000 && (n_acc < 40 || exp_q.size() != 0 || bus.rsp_valid); cyc++) begin
      @(negedge clk);
      bus.rsp_ready = (n_acc >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL rand_spurious: got rsp %b want none",
                                        {bus.rsp_flags, bus.rsp_data});
        else begin
          e = exp_q.pop_front();
          if ({bus.rsp_flags, bus.rsp_data} !== e)
            $display("FAIL rand_rsp: got %b want %b", {bus.rsp_flags, bus.rsp_data}, e);
          else passed++;
        end
      end
      // Request fields change every cycle; only the values at accept matter.
      bus.req_valid = (n_acc < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.req_a     = 2'($urandom_range(0, 3));
      bus.req_b     = 2'($urandom_range(0, 3));
      bus.req_sel   = 3'($urandom_range(0, 7));
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(alu_ref(bus.req_a, bus.req_b, bus.req_sel));
        n_acc++;
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || n_acc != 40)
      $display("FAIL rand_complete: got outstanding=%0d accepted=%0d want 0 and 40",
               exp_q.size(), n_acc);
    else passed++;
    checks++;
    if (op_count !== base + 8'd40) $display("FAIL rand_op_count: got %0d want %0d", op_count,
                                            base + 8'd40);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    issue(2'b11, 2'b11, 3'b001);
    void'(exp_q.pop_back());
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel, op_count, bus.rsp_valid, bus.req_ready} !== 17'd0)
      $display("FAIL mid_wait_reset: got %h want 0",
               {bus.alu_a, bus.alu_b, bus.alu_sel, op_count, bus.rsp_valid, bus.req_ready});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.rsp_valid, op_count} !== 9'd0)
      $display("FAIL mid_wait_discard: got valid=%0b count=%0d want 0 0", bus.rsp_valid, op_count);
    else passed++;
  endtask

`ifdef STICKY_FLAGS_EN
  task automatic test_sticky();
    checks++;
    if (sticky_flags !== 3'b000) $display("FAIL sticky_reset: got %b want 000", sticky_flags);
    else passed++;
    issue(2'b11, 2'b01, 3'b000);
    issue(2'b11, 2'b01, 3'b010);
    @(negedge clk);
    checks++;
    if (sticky_flags[0] !== 1'b1) $display("FAIL sticky_carry: got %b want 1", sticky_flags[0]);
    else passed++;
    issue(2'b01, 2'b01, 3'b000);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    checks++;
    if (sticky_flags !== 3'b010) $display("FAIL sticky_clr_push: got %b want 010", sticky_flags);
    else passed++;
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
`ifdef STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
